// File: rtl/memory_stage_pkg.sv
// Shared pipeline and data-bus types for the memory-access stage.
package memory_stage_pkg;

  typedef logic [63:0] word_t;
  typedef logic [31:0] u32_t;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    msize_t memsize;
  } control_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] mcause;
  } excep_t;

  typedef struct packed {
    logic       valid;
    word_t      pc;
    u32_t       raw_instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      aluout;
    word_t      memwd;
    logic [11:0] csraddr;
    word_t      csrdata;
    excep_t     excep;
    logic [1:0] priviledgeMode;
    logic [1:0] priviledgeMode_new;
    creg_addr_t ra1;
    creg_addr_t ra2;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    word_t      pc;
    u32_t       raw_instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
    logic [11:0] csraddr;
    word_t      csrdata;
    excep_t     excep;
    logic [1:0] priviledgeMode;
    logic [1:0] priviledgeMode_new;
    creg_addr_t ra1;
    creg_addr_t ra2;
  } memory_data_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  localparam logic [5:0] MCAUSE_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] MCAUSE_STORE_MISALIGNED = 6'd6;

  function automatic logic [7:0] size_mask(input msize_t size);
    logic [7:0] mask;
    case (size)
      MSIZE1:  mask = 8'h01;
      MSIZE2:  mask = 8'h03;
      MSIZE4:  mask = 8'h0f;
      MSIZE8:  mask = 8'hff;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-bus request/response pair between the memory stage and memory.
interface memory_stage_if;
  import memory_stage_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_stage_align.sv
// Combinational byte-lane steering: store data/strobe placement and
// load-data extraction with sign or zero extension.
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0] off,
  input  msize_t     memsize,
  input  logic       unsigned_ld,
  input  word_t      wdata,
  input  word_t      rdata,
  output word_t      wdata_aligned,
  output logic [7:0] strobe,
  output word_t      rdata_ext
);

  logic [5:0] shamt_s;
  word_t      raw_s;

  // Lane shift for stores and loads, then width-specific extension.
  always_comb begin
    shamt_s       = {off, 3'b000};
    wdata_aligned = wdata << shamt_s;
    strobe        = size_mask(memsize) << off;
    raw_s         = rdata >> shamt_s;
    case (memsize)
      MSIZE1:  rdata_ext = unsigned_ld ? {56'd0, raw_s[7:0]}  : {{56{raw_s[7]}},  raw_s[7:0]};
      MSIZE2:  rdata_ext = unsigned_ld ? {48'd0, raw_s[15:0]} : {{48{raw_s[15]}}, raw_s[15:0]};
      MSIZE4:  rdata_ext = unsigned_ld ? {32'd0, raw_s[31:0]} : {{32{raw_s[31]}}, raw_s[31:0]};
      MSIZE8:  rdata_ext = raw_s;
      default: rdata_ext = raw_s;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: issues data-bus transactions for loads and
// stores, stalls the front end while one is outstanding, and feeds writeback.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  execute_data_t  dataE,
  input  logic           mem_misaligned,
  input  logic           flush,
  input  logic           stall_in,
  memory_stage_if.master dbus,
  output memory_data_t   dataM,
  output logic           mem_stall
);

  mem_state_t    state_r, state_next_s;
  logic          kill_r, kill_next_s;
  execute_data_t held_r;
  word_t         result_r;
  execute_data_t src_s;
  memory_data_t  pass_s, data_m_s;
  dbus_req_t     req_s;
  logic          is_mem_s, need_s, misaligned_s;
  logic          req_valid_s, stall_s, capture_s, latch_s;
  word_t         st_data_s, ld_data_s;
  logic [7:0]    st_strobe_s;
  logic          unused_addr_ok_s;

  assign unused_addr_ok_s = dbus.dresp.addr_ok;

  // Operand source: live execute data while idle, the copy captured at issue otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      src_s = dataE;
    end else begin
      src_s = held_r;
    end
    is_mem_s     = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);
    need_s       = is_mem_s & ~mem_misaligned;
    misaligned_s = is_mem_s & mem_misaligned;
  end

  mem_align u_align (
    .off           (src_s.aluout[2:0]),
    .memsize       (src_s.ctl.memsize),
    .unsigned_ld   (src_s.raw_instr[14]),
    .wdata         (src_s.memwd),
    .rdata         (dbus.dresp.data),
    .wdata_aligned (st_data_s),
    .strobe        (st_strobe_s),
    .rdata_ext     (ld_data_s)
  );

  // Pass-through view of the source instruction and the bus request built from it.
  always_comb begin
    pass_s                    = '0;
    pass_s.valid              = src_s.valid;
    pass_s.pc                 = src_s.pc;
    pass_s.raw_instr          = src_s.raw_instr;
    pass_s.ctl                = src_s.ctl;
    pass_s.dst                = src_s.dst;
    pass_s.result             = src_s.aluout;
    pass_s.csraddr            = src_s.csraddr;
    pass_s.csrdata            = src_s.csrdata;
    pass_s.excep              = src_s.excep;
    pass_s.priviledgeMode     = src_s.priviledgeMode;
    pass_s.priviledgeMode_new = src_s.priviledgeMode_new;
    pass_s.ra1                = src_s.ra1;
    pass_s.ra2                = src_s.ra2;
    req_s                     = '0;
    req_s.valid               = 1'b1;
    req_s.addr                = src_s.aluout;
    req_s.size                = src_s.ctl.memsize;
    if (src_s.ctl.memwrite) begin
      req_s.strobe = st_strobe_s;
      req_s.data   = st_data_s;
    end else begin
      req_s.strobe = 8'h00;
      req_s.data   = 64'd0;
    end
  end

  // Next-state logic, request/stall generation and writeback payload.
  always_comb begin
    state_next_s = state_r;
    kill_next_s  = kill_r;
    req_valid_s  = 1'b0;
    stall_s      = 1'b0;
    capture_s    = 1'b0;
    latch_s      = 1'b0;
    data_m_s     = '0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          data_m_s       = pass_s;
          data_m_s.valid = 1'b0;
        end else if (need_s) begin
          req_valid_s = 1'b1;
          stall_s     = 1'b1;
          capture_s   = 1'b1;
          if (dbus.dresp.data_ok) begin
            latch_s      = 1'b1;
            state_next_s = DONE;
          end else begin
            state_next_s = BUSY;
          end
        end else begin
          data_m_s = pass_s;
          if (misaligned_s) begin
            data_m_s.excep.valid  = 1'b1;
            data_m_s.excep.mcause = src_s.ctl.memread ? MCAUSE_LOAD_MISALIGNED
                                                      : MCAUSE_STORE_MISALIGNED;
            data_m_s.ctl.regwrite = 1'b0;
            data_m_s.ctl.memwrite = 1'b0;
          end else begin
            data_m_s.excep = src_s.excep;
          end
        end
      end
      BUSY: begin
        // A flushed transaction still runs to completion; kill only drops its result.
        req_valid_s = 1'b1;
        stall_s     = 1'b1;
        if (dbus.dresp.data_ok) begin
          latch_s      = 1'b1;
          kill_next_s  = 1'b0;
          state_next_s = (kill_r | flush) ? IDLE : DONE;
        end else begin
          kill_next_s = kill_r | flush;
        end
      end
      DONE: begin
        data_m_s       = pass_s;
        data_m_s.result = result_r;
        data_m_s.valid = src_s.valid & ~flush;
        kill_next_s    = 1'b0;
        if (flush) begin
          state_next_s = IDLE;
        end else if (stall_in) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        kill_next_s  = 1'b0;
      end
    endcase
  end

  // State, kill flag, issued instruction and returned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      kill_r   <= 1'b0;
      held_r   <= '0;
      result_r <= 64'd0;
    end else begin
      state_r <= state_next_s;
      kill_r  <= kill_next_s;
      if (capture_s) begin
        held_r <= dataE;
      end
      if (latch_s) begin
        result_r <= src_s.ctl.memread ? ld_data_s : src_s.aluout;
      end
    end
  end

  // Output drive; everything reads as zero while reset is asserted.
  always_comb begin
    if (reset) begin
      dbus.dreq = '0;
      dataM     = '0;
      mem_stall = 1'b0;
    end else begin
      dbus.dreq = req_valid_s ? req_s : '0;
      dataM     = data_m_s;
      mem_stall = stall_s;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: handshake timing, store alignment, load
// extension, misalignment traps, flush/kill, stall_in hold and reset.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam logic [31:0] RAW_ADD = 32'h0000_0033;
  localparam logic [31:0] RAW_LB  = 32'h0000_0003;
  localparam logic [31:0] RAW_LBU = 32'h0000_4003;
  localparam logic [31:0] RAW_LW  = 32'h0000_2003;
  localparam logic [31:0] RAW_LD  = 32'h0000_3003;
  localparam logic [31:0] RAW_SH  = 32'h0000_1023;
  localparam logic [31:0] RAW_SW  = 32'h0000_2023;
  localparam logic [63:0] PC      = 64'h0000_0000_8000_1000;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          mem_misaligned;
  logic          flush;
  logic          stall_in;
  memory_data_t  dataM;
  logic          mem_stall;
  int            tests = 0;
  int            failed = 0;

  memory_stage_if bus();

  memory_stage dut (
    .clk            (clk),
    .reset          (reset),
    .dataE          (dataE),
    .mem_misaligned (mem_misaligned),
    .flush          (flush),
    .stall_in       (stall_in),
    .dbus           (bus),
    .dataM          (dataM),
    .mem_stall      (mem_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic execute_data_t mk(input logic [31:0] raw, input word_t alu, input word_t wd,
                                       input logic rd, input logic wr, input msize_t sz,
                                       input logic rw);
    execute_data_t e;
    e                 = '0;
    e.valid           = 1'b1;
    e.pc              = PC;
    e.raw_instr       = raw;
    e.ctl.regwrite    = rw;
    e.ctl.memread     = rd;
    e.ctl.memwrite    = wr;
    e.ctl.memsize     = sz;
    e.dst             = 5'd10;
    e.aluout          = alu;
    e.memwd           = wd;
    return e;
  endfunction

  // Zero-wait access issued from IDLE; leaves the stage in DONE with dataE cleared.
  task automatic quick_access(input string tag, input execute_data_t e, input word_t rdata,
                              input word_t exp_result);
    dataE               = e;
    bus.dresp.data      = rdata;
    bus.dresp.data_ok   = 1'b1;
    settle();
    check({tag, "_req_valid"}, 64'(bus.dreq.valid), 64'd1);
    check({tag, "_req_addr"},  bus.dreq.addr, e.aluout);
    check({tag, "_stall"},     64'(mem_stall), 64'd1);
    step();
    bus.dresp.data_ok = 1'b0;
    dataE             = '0;
    settle();
    check({tag, "_valid"},  64'(dataM.valid), 64'd1);
    check({tag, "_result"}, dataM.result, exp_result);
    check({tag, "_stall_done"}, 64'(mem_stall), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    dataE          = '0;
    mem_misaligned = 1'b0;
    flush          = 1'b0;
    stall_in       = 1'b0;
    bus.dresp      = '0;
    step();
    step();
    settle();
    check("rst_dreq",  64'(|bus.dreq), 64'd0);
    check("rst_dataM", 64'(|dataM), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    reset = 1'b0;

    // Non-memory instruction passes straight through.
    dataE = mk(RAW_ADD, 64'h1234, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b1);
    settle();
    check("add_result", dataM.result, 64'h1234);
    check("add_valid",  64'(dataM.valid), 64'd1);
    check("add_pc",     dataM.pc, PC);
    check("add_stall",  64'(mem_stall), 64'd0);
    check("add_dreq",   64'(bus.dreq.valid), 64'd0);
    step();

    quick_access("lb3", mk(RAW_LB, 64'h1003, 64'd0, 1'b1, 1'b0, MSIZE1, 1'b1),
                 64'h8000_0000_0000_0000, 64'h0);
    check("lb3_pc", dataM.pc, PC);
    step();
    quick_access("lb7", mk(RAW_LB, 64'h1007, 64'd0, 1'b1, 1'b0, MSIZE1, 1'b1),
                 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    quick_access("lbu7", mk(RAW_LBU, 64'h1007, 64'd0, 1'b1, 1'b0, MSIZE1, 1'b1),
                 64'h8000_0000_0000_0000, 64'h80);
    step();

    // SH with data_ok three cycles after the request rises.
    dataE = mk(RAW_SH, 64'h2006, 64'hBEEF, 1'b0, 1'b1, MSIZE2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      bus.dresp.data_ok = (c == 3);
      settle();
      check("sh_stall",  64'(mem_stall), 64'd1);
      check("sh_req",    64'(bus.dreq.valid), 64'd1);
      check("sh_strobe", 64'(bus.dreq.strobe), 64'hC0);
      check("sh_data",   bus.dreq.data, 64'hBEEF_0000_0000_0000);
      check("sh_addr",   bus.dreq.addr, 64'h2006);
      check("sh_busy_valid", 64'(dataM.valid), 64'd0);
      step();
    end
    bus.dresp.data_ok = 1'b0;
    settle();
    check("sh_done_stall", 64'(mem_stall), 64'd0);
    check("sh_done_valid", 64'(dataM.valid), 64'd1);
    check("sh_done_rw",    64'(dataM.ctl.regwrite), 64'd0);
    dataE = '0;
    step();

    // Misaligned load and store trap without touching the bus.
    dataE          = mk(RAW_LD, 64'h3004, 64'd0, 1'b1, 1'b0, MSIZE8, 1'b1);
    mem_misaligned = 1'b1;
    settle();
    check("mis_ld_req",    64'(bus.dreq.valid), 64'd0);
    check("mis_ld_stall",  64'(mem_stall), 64'd0);
    check("mis_ld_valid",  64'(dataM.valid), 64'd1);
    check("mis_ld_exc",    64'(dataM.excep.valid), 64'd1);
    check("mis_ld_cause",  64'(dataM.excep.mcause), 64'd4);
    check("mis_ld_rw",     64'(dataM.ctl.regwrite), 64'd0);
    step();
    dataE = mk(RAW_SW, 64'h3002, 64'h55, 1'b0, 1'b1, MSIZE4, 1'b0);
    settle();
    check("mis_sw_req",    64'(bus.dreq.valid), 64'd0);
    check("mis_sw_cause",  64'(dataM.excep.mcause), 64'd6);
    check("mis_sw_mw",     64'(dataM.ctl.memwrite), 64'd0);
    step();
    mem_misaligned = 1'b0;

    // LW flushed in its second BUSY cycle; data_ok two cycles later.
    dataE = mk(RAW_LW, 64'h5000, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b1);
    bus.dresp.data = 64'h0000_0000_1234_5678;
    for (int c = 0; c < 5; c++) begin
      flush             = (c == 2);
      bus.dresp.data_ok = (c == 4);
      settle();
      check("kill_req",   64'(bus.dreq.valid), 64'd1);
      check("kill_stall", 64'(mem_stall), 64'd1);
      check("kill_valid", 64'(dataM.valid), 64'd0);
      step();
    end
    flush             = 1'b0;
    bus.dresp.data_ok = 1'b0;
    dataE             = mk(RAW_ADD, 64'h77, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b1);
    settle();
    check("kill_idle_result", dataM.result, 64'h77);
    check("kill_idle_valid",  64'(dataM.valid), 64'd1);
    check("kill_idle_req",    64'(bus.dreq.valid), 64'd0);
    step();

    // Flush in IDLE suppresses the request; a stray data_ok is ignored.
    dataE             = mk(RAW_LW, 64'h5008, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b1);
    flush             = 1'b1;
    bus.dresp.data_ok = 1'b1;
    settle();
    check("fl_idle_req",   64'(bus.dreq.valid), 64'd0);
    check("fl_idle_stall", 64'(mem_stall), 64'd0);
    check("fl_idle_valid", 64'(dataM.valid), 64'd0);
    step();
    flush             = 1'b0;
    bus.dresp.data_ok = 1'b0;
    dataE             = mk(RAW_ADD, 64'h99, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b1);
    settle();
    check("stray_ok_result", dataM.result, 64'h99);
    check("stray_ok_req",    64'(bus.dreq.valid), 64'd0);
    step();

    // Reset while BUSY.
    dataE = mk(RAW_LW, 64'h6000, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b1);
    settle();
    check("rb_req", 64'(bus.dreq.valid), 64'd1);
    step();
    reset = 1'b1;
    step();
    settle();
    check("rb_dreq",  64'(|bus.dreq), 64'd0);
    check("rb_dataM", 64'(|dataM), 64'd0);
    check("rb_stall", 64'(mem_stall), 64'd0);
    reset = 1'b0;
    dataE = '0;
    settle();
    check("rb_idle_dataM", 64'(|dataM), 64'd0);
    check("rb_idle_req",   64'(bus.dreq.valid), 64'd0);
    check("rb_idle_stall", 64'(mem_stall), 64'd0);
    dataE = mk(RAW_ADD, 64'hAA, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b1);
    settle();
    check("rb_add_result", dataM.result, 64'hAA);
    step();

    // stall_in held two cycles in DONE keeps dataM steady for three.
    dataE             = mk(RAW_LD, 64'h4000, 64'd0, 1'b1, 1'b0, MSIZE8, 1'b1);
    bus.dresp.data    = 64'h1122_3344_5566_7788;
    bus.dresp.data_ok = 1'b1;
    settle();
    step();
    bus.dresp.data_ok = 1'b0;
    bus.dresp.data    = 64'd0;
    for (int c = 0; c < 3; c++) begin
      stall_in = (c < 2);
      settle();
      check("hold_valid",  64'(dataM.valid), 64'd1);
      check("hold_result", dataM.result, 64'h1122_3344_5566_7788);
      check("hold_stall",  64'(mem_stall), 64'd0);
      if (c == 2) dataE = '0;
      step();
    end
    stall_in = 1'b0;
    settle();
    check("hold_after_valid", 64'(dataM.valid), 64'd0);
    check("hold_after_req",   64'(bus.dreq.valid), 64'd0);
    step();

    // Flush beats stall_in in DONE.
    dataE             = mk(RAW_LD, 64'h4008, 64'd0, 1'b1, 1'b0, MSIZE8, 1'b1);
    bus.dresp.data    = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.dresp.data_ok = 1'b1;
    settle();
    step();
    bus.dresp.data_ok = 1'b0;
    stall_in          = 1'b1;
    flush             = 1'b1;
    settle();
    check("fl_done_valid", 64'(dataM.valid), 64'd0);
    dataE = mk(RAW_ADD, 64'hBB, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b1);
    step();
    flush    = 1'b0;
    stall_in = 1'b0;
    settle();
    check("fl_done_next_result", dataM.result, 64'hBB);
    check("fl_done_next_valid",  64'(dataM.valid), 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access pipeline stage; consumes the execute stage's `execute_data_t` and the misalignment flag it produces. Drives the data bus (`dbus_req_t` / `dbus_resp_t`) with a valid-held-until-`data_ok` handshake. Aligns store data and strobes, and extracts and extends load data. Emits `memory_data_t` to writeback, and stalls the front of the pipeline while a bus transaction is outstanding.

## Interface
- No parameters. Widths come from `common` (`word_t` is 64 bits; the data bus is 64 bits with an 8-bit strobe).
- `clk` input, 1: clock. Reset is synchronous and active-high.
- `reset` input, 1: synchronous, active-high reset.
- `dataE` input, `execute_data_t`: execute result. It is held stable by upstream while `mem_stall` is 1.
- `mem_misaligned` input, 1: execute-stage misalignment flag for `dataE`.
- `flush` input, 1: kill the instruction currently in this stage (trap/mret redirect).
- `stall_in` input, 1: downstream is not accepting `dataM` this cycle.
- `dreq` output, `dbus_req_t`: fields `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp` input, `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data`.
- `dataM` output, `memory_data_t`: stage result to writeback.
- `mem_stall` output, 1: hold the E/M register and all earlier stages.

## Operation
- An access is needed when `need = dataE.valid & (ctl.memread | ctl.memwrite) & !mem_misaligned`.
- FSM states are `IDLE`, `BUSY`, `DONE`, plus a 1-bit `kill` register.
- In `IDLE`:
  - If `need` is 1, drive `dreq.valid=1` and assert `mem_stall`.
  - If `data_ok` arrives in the same cycle, go to `DONE`; otherwise go to `BUSY`.
  - If `need` is 0, pass `dataE` straight through combinationally with result = `dataE.aluout`.
- In `BUSY`: hold `dreq` constant with `valid=1` and `mem_stall=1`. On `data_ok`, latch `dresp.data` and go to `DONE`.
- In `DONE`:
  - `mem_stall=0`. `dataM` is built from the latched result and registered `dataE` fields.
  - If `stall_in` is 1, remain in `DONE`. Otherwise return to `IDLE` at the next edge.
- `flush` in `IDLE`: `dataM.valid=0` and no request is issued.
- `flush` in `BUSY`: the bus transaction is not abandoned.
  - Set `kill`, finish the transaction, and go to `IDLE` directly; `DONE` is never entered.
  - The killed result is never presented (`dataM.valid=0`).
- `flush` in `DONE`: `dataM.valid=0` and go to `IDLE`.
- Misaligned access: no bus request. `dataM` is valid and carries the exception: `excep` with mcause 4 for a load, 6 for a store. `ctl.regwrite` and `ctl.memwrite` are cleared.
- Store alignment uses `off = addr[2:0]`:
  - `dreq.data = memwd << (8*off)`.
  - `strobe` is `8'h01` / `8'h03` / `8'h0f` / `8'hff` for `MSIZE1` / `MSIZE2` / `MSIZE4` / `MSIZE8`, shifted left by `off`.
  - For loads, `strobe = 0`. `dreq.addr = dataE.aluout` and `dreq.size = ctl.memsize`.
- Load extraction:
  - `raw = dresp.data >> (8*off)`, truncated to the access size.
  - Zero-extend if `raw_instr[14]` is 1 (LBU/LHU/LWU); otherwise sign-extend.
  - `MSIZE8` is taken unchanged.
- Pass-through fields: `pc`, `raw_instr`, `ctl`, `dst`, `csraddr`, `csrdata`, `excep`, `priviledgeMode`, `priviledgeMode_new`, `ra1`, `ra2`.
  - These come from a register captured at issue while in `BUSY`/`DONE`, and combinationally from `dataE` in `IDLE`.

## Timing
- Reset values: state `IDLE`, `kill=0`, `dreq` all zero, `mem_stall=0`, `dataM` all zero (`valid=0`).
- Reset mid-transaction drops to `IDLE` at the next edge. `dreq.valid` is 0 in the cycle after reset.
- Non-memory instructions: 0 cycles in this stage (combinational), no stall.
- Memory access whose `data_ok` arrives N cycles after `dreq.valid` first rises (N≥0): `mem_stall` is high for N+1 cycles, and `dataM` is valid exactly in the cycle after `data_ok`.
- `dreq` fields stay stable from rise to `data_ok`. `addr_ok` is ignored for control flow.
- `data_ok` while `dreq.valid=0` is ignored.
- `flush` and `data_ok` in the same cycle: the result is discarded and the next state is `IDLE`.
- `flush` has priority over `stall_in` in `DONE`.

## Structure
- Add `memory_data_t` (fields above plus `result` as `word_t`) to `pipes`.
- Add the `mem_state_t` enum to `pipes`.
- Sub-module `mem_align` (combinational): store data/strobe generation and load extract/extend. Inputs are `addr[2:0]`, `memsize`, the unsigned flag, `wdata` and `rdata`.

## Test plan
- ADD with `aluout=0x1234` → `dataM.result=0x1234` in the same cycle, `mem_stall=0`, `dreq.valid=0`.
- LB at addr `0x1003` with `dresp.data=0x80_00_00_00_00_00_00_00` → extracted byte is `0x00`, result 0. Repeat at addr `0x1007` → result `0xFFFFFFFFFFFFFF80`. LBU at `0x1007` → result `0x80`.
- SH at addr `0x2006` with `memwd=0xBEEF` → `strobe=8'hC0`, `data=0xBEEF000000000000`. `data_ok` after 3 cycles → `mem_stall` high 4 cycles, `dataM.valid` on the 5th.
- LD at `0x3004` (misaligned) → no `dreq.valid`, `dataM.excep` mcause 4, `regwrite=0`.
- LW with `flush` in the 2nd `BUSY` cycle and `data_ok` 2 cycles later → the request completes, `dataM.valid` is never asserted, the FSM returns to `IDLE`.
- `reset` asserted during `BUSY` → next cycle `dreq.valid=0`, state `IDLE`, `dataM=0`. `stall_in` held 2 cycles in `DONE` → `dataM` holds steady for 3 cycles.
